// File: rtl/disto16x16_acc.sv
// disto16x16_acc: sums NUM_BLK clamped 4x4 distortions for one macroblock and applies
// the rounded tlambda weight. Define DISTO16_DROP_CNT_EN to add the drop_cnt output.
module disto16x16_acc #(
    parameter int SUM_WIDTH    = 32,
    parameter int NUM_BLK      = 16,
    parameter int LAMBDA_WIDTH = 16,
    parameter int ACC_WIDTH    = 36
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [LAMBDA_WIDTH-1:0]              tlambda,
    input  logic                                 in_valid,
    input  logic signed [SUM_WIDTH-1:0]          in_sum,
    output logic                                 busy,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ACC_WIDTH-1:0]                 sd_sum,
    output logic [ACC_WIDTH+LAMBDA_WIDTH-9:0]    sd
`ifdef DISTO16_DROP_CNT_EN
    ,
    output logic [7:0]                           drop_cnt
`endif
);

    localparam int PROD_W = ACC_WIDTH + LAMBDA_WIDTH;
    localparam int SD_W   = PROD_W - 8;
    localparam int CNT_W  = $clog2(NUM_BLK + 1);
    localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(NUM_BLK - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, MULT, OUT} state_t;

    state_t                    state_q, state_d;
    logic [ACC_WIDTH-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [LAMBDA_WIDTH-1:0]   tlambda_l_q, tlambda_l_d;
    logic [ACC_WIDTH-1:0]      sd_sum_q, sd_sum_d;
    logic [SD_W-1:0]           sd_q, sd_d;

    logic [ACC_WIDTH-1:0]      blk_val;
    logic [PROD_W-1:0]         prod;
    logic [PROD_W-1:0]         prod_rnd;

    // Negative block distortions contribute nothing; positive ones are zero-extended.
    always_comb begin
        blk_val  = in_sum[SUM_WIDTH-1] ? '0 : ACC_WIDTH'(in_sum[SUM_WIDTH-2:0]);
        prod     = PROD_W'(tlambda_l_q) * PROD_W'(acc_q);
        prod_rnd = prod + PROD_W'(128);
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        tlambda_l_d = tlambda_l_q;
        sd_sum_d    = sd_sum_q;
        sd_d        = sd_q;
        // start aborts whatever is in flight and swallows a coincident in_valid.
        if (start) begin
            state_d     = ACCUM;
            acc_d       = '0;
            cnt_d       = '0;
            tlambda_l_d = tlambda;
        end else begin
            case (state_q)
                IDLE: ;
                ACCUM: begin
                    if (in_valid) begin
                        acc_d = acc_q + blk_val;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BLK) begin
                            state_d = MULT;
                        end
                    end
                end
                MULT: begin
                    sd_sum_d = acc_q;
                    sd_d     = (tlambda_l_q == '0) ? '0 : SD_W'(prod_rnd >> 8);
                    state_d  = OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            tlambda_l_q <= '0;
            sd_sum_q    <= '0;
            sd_q        <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            tlambda_l_q <= tlambda_l_d;
            sd_sum_q    <= sd_sum_d;
            sd_q        <= sd_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign sd_sum    = sd_sum_q;
    assign sd        = sd_q;

`ifdef DISTO16_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       drop;

    always_comb begin
        drop       = in_valid && (start || state_q == MULT || state_q == OUT);
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
